// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types, memory map and round-robin helper for mem_arbiter
package mem_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  localparam int MEM_ADDR_W = 11;

  // Byte-address bases of the regions the engines share in mem
  localparam logic [MEM_ADDR_W-1:0] FLAGS_BASE          = 11'h000;
  localparam logic [MEM_ADDR_W-1:0] KNOWN_SINKS_BASE    = 11'h008;
  localparam logic [MEM_ADDR_W-1:0] WORST_HOPS_BASE     = 11'h028;
  localparam logic [MEM_ADDR_W-1:0] NEIGHBOR_ID_BASE    = 11'h048;
  localparam logic [MEM_ADDR_W-1:0] CLUSTER_ID_BASE     = 11'h0C8;
  localparam logic [MEM_ADDR_W-1:0] BATTERY_BASE        = 11'h148;
  localparam logic [MEM_ADDR_W-1:0] QVALUE_BASE         = 11'h1C8;
  localparam logic [MEM_ADDR_W-1:0] SINK_IDS_BASE       = 11'h248;
  localparam logic [MEM_ADDR_W-1:0] HCM_BASE            = 11'h648;
  localparam logic [MEM_ADDR_W-1:0] BETTER_NBR_BASE     = 11'h668;
  localparam logic [MEM_ADDR_W-1:0] KNOWN_SINK_CNT_ADDR = 11'h688;
  localparam logic [MEM_ADDR_W-1:0] NEIGHBOR_CNT_ADDR   = 11'h68A;
  localparam logic [MEM_ADDR_W-1:0] BETTER_NBR_CNT_ADDR = 11'h68C;
  localparam logic [MEM_ADDR_W-1:0] SINK_ID_CNT_ADDR    = 11'h68E;

  function automatic int unsigned rr_next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rtl/mem_arbiter_rr_pick.sv - combinational round-robin selector: first request at or after ptr
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               found_o
);

  logic [NUM_REQ-1:0]   req_rot;
  logic [NUM_REQ-1:0]   first_rot;
  logic [2*NUM_REQ-1:0] gnt_wide;

  // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back
  always_comb begin
    req_rot   = NUM_REQ'({req_i, req_i} >> ptr_i);
    first_rot = '0;
    found_o   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found_o && req_rot[k]) begin
        first_rot[k] = 1'b1;
        found_o      = 1'b1;
      end
    end
    gnt_wide = {{NUM_REQ{1'b0}}, first_rot} << ptr_i;
    gnt_o    = gnt_wide[NUM_REQ-1:0] | gnt_wide[2*NUM_REQ-1:NUM_REQ];
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter/sequencer sharing mem between engines
// Optional MEM_ALIGN_CHECK_EN: reject odd/last-byte accesses, adds err and err_cnt ports.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = 11,
  parameter int WORD_W   = 16,
  parameter int MAX_HOLD = 16
) (
  input  logic                      clock,
  input  logic                      nrst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ-1:0]        wr_en_in,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_in,
  input  logic [NUM_REQ*WORD_W-1:0] wdata_in,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [WORD_W-1:0]         rdata,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [ADDR_W-1:0]         mem_address,
  output logic                      mem_wr_en,
  output logic [WORD_W-1:0]         mem_data_in,
  input  logic [WORD_W-1:0]         mem_data_out,
`ifdef MEM_ALIGN_CHECK_EN
  output logic                      err,
  output logic [7:0]                err_cnt,
`endif
  output logic                      busy
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  rvalid_q, rvalid_d;
  logic [WORD_W-1:0]   rdata_q, rdata_d;

  logic [ADDR_W-1:0]   addr_a  [NUM_REQ];
  logic [WORD_W-1:0]   wdata_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_a[i]  = addr_in[i*ADDR_W +: ADDR_W];
    assign wdata_a[i] = wdata_in[i*WORD_W +: WORD_W];
  end

  logic [ADDR_W-1:0]  own_addr;
  logic [WORD_W-1:0]  own_wdata;
  logic               own_req, own_lock, own_wr;
  logic               access, reject, do_write, do_read, release_own;
  logic [IDX_W-1:0]   next_ptr;
  logic [NUM_REQ-1:0] pick_req, pick_gnt;
  logic [IDX_W-1:0]   pick_ptr, pick_idx;
  logic               pick_found;

  assign own_addr  = addr_a[owner_q];
  assign own_wdata = wdata_a[owner_q];
  assign own_req   = req[owner_q];
  assign own_lock  = lock[owner_q];
  assign own_wr    = wr_en_in[owner_q];

  // Reset gates the access directly so a write in flight never reaches mem
  assign access   = nrst && (state_q == OWNED) && own_req;
`ifdef MEM_ALIGN_CHECK_EN
  assign reject   = access && (own_addr[0] || (&own_addr));
`else
  assign reject   = 1'b0;
`endif
  assign do_write = access && own_wr && !reject;
  assign do_read  = access && !own_wr && !reject;

  assign release_own = !own_req || !own_lock || (hold_q == HOLD_LAST);
  assign next_ptr    = IDX_W'(rr_next_idx(32'(owner_q), NUM_REQ));

  // Releasing owner is masked out so it cannot win the same edge it lets go
  assign pick_req = (state_q == OWNED) ? (req & ~gnt_q) : req;
  assign pick_ptr = (state_q == OWNED) ? next_ptr : ptr_q;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i   (pick_req),
    .ptr_i   (pick_ptr),
    .gnt_o   (pick_gnt),
    .found_o (pick_found)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) pick_idx = pick_idx | IDX_W'(i);
    end
  end

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = OWNED;
          owner_d = pick_idx;
          gnt_d   = pick_gnt;
          hold_d  = '0;
        end
      end
      OWNED: begin
        if (release_own) begin
          ptr_d  = next_ptr;
          hold_d = '0;
          if (pick_found) begin
            owner_d = pick_idx;
            gnt_d   = pick_gnt;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    ack         = access ? gnt_q : '0;
    mem_address = access ? own_addr : '0;
    mem_data_in = access ? own_wdata : '0;
    mem_wr_en   = do_write;
    rvalid_d    = do_read ? gnt_q : '0;
    rdata_d     = do_read ? mem_data_out : rdata_q;
  end

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic       err_q;
  logic [7:0] err_cnt_q, err_cnt_d;

  assign err_cnt_d = (reject && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q     <= reject;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err     = err_q;
  assign err_cnt = err_cnt_q;
`endif

  assign gnt    = gnt_q;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign busy   = |gnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized and directed bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;

  localparam int N        = 4;
  localparam int AW       = 11;
  localparam int WW       = 16;
  localparam int MAX_HOLD = 16;
  localparam int MSIZE    = 2048;

  logic            clock = 1'b0;
  logic            nrst  = 1'b0;
  logic [N-1:0]    req = '0, lock = '0, wr_en_in = '0;
  logic [N*AW-1:0] addr_in = '0;
  logic [N*WW-1:0] wdata_in = '0;
  logic [N-1:0]    gnt, ack, rvalid;
  logic [WW-1:0]   rdata, mem_data_in, mem_data_out;
  logic [AW-1:0]   mem_address;
  logic            mem_wr_en, busy;
`ifdef MEM_ALIGN_CHECK_EN
  logic            err;
  logic [7:0]      err_cnt;
`endif

  mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .WORD_W(WW), .MAX_HOLD(MAX_HOLD)) dut (
    .clock(clock), .nrst(nrst), .req(req), .lock(lock), .wr_en_in(wr_en_in),
    .addr_in(addr_in), .wdata_in(wdata_in), .gnt(gnt), .ack(ack), .rdata(rdata),
    .rvalid(rvalid), .mem_address(mem_address), .mem_wr_en(mem_wr_en),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
`ifdef MEM_ALIGN_CHECK_EN
    .err(err), .err_cnt(err_cnt),
`endif
    .busy(busy)
  );

  always #5 clock = ~clock;

  // Byte-wide memory: high byte at address, low byte at address+1
  logic [7:0] mem_b   [MSIZE];
  logic [7:0] ref_mem [MSIZE];
  assign mem_data_out = {mem_b[mem_address], mem_b[mem_address + 11'd1]};
  always @(posedge clock) begin
    if (mem_wr_en) begin
      mem_b[mem_address]         <= mem_data_in[15:8];
      mem_b[mem_address + 11'd1] <= mem_data_in[7:0];
    end
  end

  // Reference model: who owns the memory, whose turn is next, burst length so far
  bit            m_owned;
  int            m_owner, m_ptr, m_hold;
  logic [N-1:0]  m_rvalid;
  logic [WW-1:0] m_rdata;
  bit            m_err;
  int            m_errcnt;

  logic [N-1:0]  got_ack;
  logic          got_wen;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit bad_addr(input int a);
`ifdef MEM_ALIGN_CHECK_EN
    return (a % 2 == 1) || (a == MSIZE - 1);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int first_from(input int p, input int skip);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (j != skip && req[j]) return j;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_owned = 0; m_owner = 0; m_ptr = 0; m_hold = 0;
    m_rvalid = '0; m_rdata = '0; m_err = 0; m_errcnt = 0;
  endfunction

  task automatic set_rq(input int i, input bit r, input bit l, input bit w, input int a, input int d);
    req[i] = r; lock[i] = l; wr_en_in[i] = w;
    addr_in[i*AW +: AW] = AW'(a);
    wdata_in[i*WW +: WW] = WW'(d);
  endtask

  // One clock: inputs already driven; check combinational outputs, advance model, check registers
  task automatic step();
    logic [N-1:0] e_ack;
    bit acc, rej, e_wen, is_wr;
    int o, a, d, w;
    e_ack = '0; acc = 0; rej = 0; e_wen = 0; is_wr = 0; a = 0; d = 0;
    o = m_owner;
    if (m_owned && req[o]) begin
      acc = 1; e_ack[o] = 1'b1;
      a = int'(addr_in[o*AW +: AW]);
      d = int'(wdata_in[o*WW +: WW]);
      is_wr = wr_en_in[o];
      rej = bad_addr(a);
      e_wen = is_wr && !rej;
    end
    #1;
    got_ack = ack;
    got_wen = mem_wr_en;
    check_eq("ack", 32'(ack), 32'(e_ack));
    check_eq("mem_wr_en", 32'(mem_wr_en), 32'(e_wen));
    if (acc || !m_owned) check_eq("mem_address", 32'(mem_address), 32'(a));
    if (e_wen) check_eq("mem_data_in", 32'(mem_data_in), 32'(d));

    m_rvalid = '0;
    if (acc && !rej && !is_wr) begin
      m_rvalid[o] = 1'b1;
      m_rdata = {ref_mem[a], ref_mem[(a + 1) % MSIZE]};
    end
    if (e_wen) begin
      ref_mem[a] = 8'(d >> 8);
      ref_mem[(a + 1) % MSIZE] = 8'(d);
    end
    m_err = rej;
    if (rej && m_errcnt < 255) m_errcnt++;

    if (!m_owned) begin
      w = first_from(m_ptr, -1);
      if (w >= 0) begin m_owned = 1; m_owner = w; m_hold = 0; end
    end else if (!req[o] || !lock[o] || m_hold == MAX_HOLD - 1) begin
      m_ptr = (o + 1) % N;
      w = first_from(m_ptr, o);
      if (w >= 0) begin m_owner = w; m_hold = 0; end
      else m_owned = 0;
    end else begin
      m_hold++;
    end

    @(posedge clock);
    #1;
    check_eq("gnt", 32'(gnt), m_owned ? (32'd1 << m_owner) : 32'd0);
    check_eq("busy", 32'(busy), 32'(m_owned));
    check_eq("rvalid", 32'(rvalid), 32'(m_rvalid));
    if (m_rvalid != '0) check_eq("rdata", 32'(rdata), 32'(m_rdata));
`ifdef MEM_ALIGN_CHECK_EN
    check_eq("err", 32'(err), 32'(m_err));
    check_eq("err_cnt", 32'(err_cnt), 32'(m_errcnt));
`endif
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    req = '0; lock = '0; wr_en_in = '0;
    @(posedge clock);
    #1;
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_rvalid", 32'(rvalid), 32'd0);
    check_eq("rst_rdata", 32'(rdata), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_wr_en", 32'(mem_wr_en), 32'd0);
    model_reset();
    nrst = 1'b1;
  endtask

  initial begin
    int cnt, ord, rd_ok, mism;
    logic [15:0] keep;
    for (int a = 0; a < MSIZE; a++) begin
      logic [7:0] v;
      v = 8'($urandom);
      mem_b[a] = v; ref_mem[a] = v;
    end
    mem_b[11'h688] = 8'h00; ref_mem[11'h688] = 8'h00;
    mem_b[11'h689] = 8'h05; ref_mem[11'h689] = 8'h05;
    mem_b[11'h008] = 8'hAA; ref_mem[11'h008] = 8'hAA;
    model_reset();

    // Single write
    do_reset();
    set_rq(0, 1, 0, 1, 'h008, 'h0002);
    step();
    step();
    check_eq("t1_ack", 32'(got_ack), 32'h1);
    req = '0;
    check_eq("t1_byte_hi", 32'(mem_b[11'h008]), 32'h00);
    check_eq("t1_byte_lo", 32'(mem_b[11'h009]), 32'h02);
    step();

    // Four readers, no lock
    do_reset();
    for (int i = 0; i < N; i++) set_rq(i, 1, 0, 0, 'h688, 0);
    ord = 0; rd_ok = 0;
    for (int c = 0; c < 12 && (req != '0 || rvalid != '0); c++) begin
      step();
      for (int i = 0; i < N; i++) if (got_ack[i]) ord = (ord << 4) | i;
      req = req & ~got_ack;
      if (rvalid != '0 && rdata == 16'h0005) rd_ok++;
    end
    check_eq("t2_order", 32'(ord), 32'h0123);
    check_eq("t2_rdata_cnt", 32'(rd_ok), 32'd4);

    // Locked burst with a competitor
    do_reset();
    set_rq(1, 1, 1, 0, 'h048, 0);
    set_rq(2, 1, 0, 0, 'h0C8, 0);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (got_ack[1]) cnt++;
      if (gnt[2]) break;
    end
    check_eq("t3_burst_len", 32'(cnt), 32'd16);
    check_eq("t3_gnt_moved", 32'(gnt), 32'h4);
    req[1] = 1'b0; lock[1] = 1'b0;
    step();
    req = req & ~got_ack;
    step();

    // Owner drops request
    do_reset();
    set_rq(3, 1, 0, 1, 'h100, 'h1234);
    step();
    req[3] = 1'b0;
    set_rq(0, 1, 0, 0, 'h200, 0);
    step();
    check_eq("t4_no_ack", 32'(got_ack), 32'h0);
    check_eq("t4_no_wr", 32'(got_wen), 32'h0);
    check_eq("t4_gnt0", 32'(gnt), 32'h1);
    step();
    req = '0;
    step();

    // Reset during a burst write
    do_reset();
    set_rq(2, 1, 1, 1, 'h300, 'h1111);
    step();
    step();
    wdata_in[2*WW +: WW] = 16'h2222;
    step();
    wdata_in[2*WW +: WW] = 16'h3333;
    #1;
    nrst = 1'b0;
    #1;
    check_eq("t5_gnt", 32'(gnt), 32'h0);
    check_eq("t5_rvalid", 32'(rvalid), 32'h0);
    check_eq("t5_wr_en", 32'(mem_wr_en), 32'h0);
    check_eq("t5_ack", 32'(ack), 32'h0);
    @(posedge clock);
    #1;
    model_reset();
    check_eq("t5_no_write", 32'({mem_b[11'h300], mem_b[11'h301]}), 32'h2222);
    req = '0; lock = '0; wr_en_in = '0;
    set_rq(0, 1, 0, 0, 'h400, 0);
    set_rq(2, 1, 0, 0, 'h402, 0);
    nrst = 1'b1;
    step();
    check_eq("t5_gnt0", 32'(gnt), 32'h1);
    req = '0;
    step();
    step();

`ifdef MEM_ALIGN_CHECK_EN
    // Rejected write to the last byte
    do_reset();
    keep = {mem_b[11'h7FF], mem_b[11'h000]};
    set_rq(0, 1, 0, 1, 'h7FF, 'hABCD);
    step();
    step();
    check_eq("t6_ack", 32'(got_ack), 32'h1);
    check_eq("t6_err", 32'(err), 32'h1);
    check_eq("t6_err_cnt", 32'(err_cnt), 32'h1);
    check_eq("t6_mem", 32'({mem_b[11'h7FF], mem_b[11'h000]}), 32'(keep));
    req = '0;
    step();
`endif

    // Random traffic
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        bit fresh;
        fresh = 0;
        if (!req[i]) begin
          fresh = ($urandom % 2) == 1;
        end else if (got_ack[i]) begin
          fresh = ($urandom % 3) == 0;
          req[i] = 1'b0;
        end else if ($urandom % 20 == 0) begin
          req[i] = 1'b0;
        end
        if (fresh) begin
          int a;
`ifdef MEM_ALIGN_CHECK_EN
          a = ($urandom % 4 == 0) ? int'($urandom % MSIZE) : int'(($urandom % (MSIZE / 2)) * 2);
`else
          a = int'(($urandom % (MSIZE / 2)) * 2);
`endif
          set_rq(i, 1, lock[i], $urandom % 2, a, int'($urandom % 65536));
        end
        lock[i] = ($urandom % 4) != 0;
      end
      step();
    end
    req = '0;
    step();
    step();

    mism = 0;
    for (int a = 0; a < MSIZE; a++) if (mem_b[a] !== ref_mem[a]) mism++;
    check_eq("mem_final", 32'(mism), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Round-robin arbiter and sequencer that shares the single-port word memory (`mem`, 11-bit byte address, 16-bit word, synchronous write, combinational read) between NUM_REQ processing engines (e.g. findMyBest, fixSinkList, neighbor/sink scanners).
- Sits between the engines and `mem`; it is the only driver of `mem`'s address, wr_en and data_in.
- Provides grant/ack handshakes, optional burst locking with a bounded hold, and registered read data.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 11, memory byte-address width.
- WORD_W, 16, memory word width.
- MAX_HOLD, 16, maximum consecutive accesses one owner may make under lock (>=1).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- nrst  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester access request; held high until ack.
- lock  in  NUM_REQ  requester asks to keep its grant after the current access (burst).
- wr_en_in  in  NUM_REQ  1 = write, 0 = read, per requester.
- addr_in  in  NUM_REQ*ADDR_W  packed byte addresses; requester i at [i*ADDR_W +: ADDR_W].
- wdata_in  in  NUM_REQ*WORD_W  packed write words.
- gnt  out  NUM_REQ  registered one-hot grant.
- ack  out  NUM_REQ  combinational; high in the cycle requester i's access is performed.
- rdata  out  WORD_W  registered read word.
- rvalid  out  NUM_REQ  registered one-hot; rdata belongs to the flagged requester.
- mem_address  out  ADDR_W  to mem address.
- mem_wr_en  out  1  to mem wr_en.
- mem_data_in  out  WORD_W  to mem data_in.
- mem_data_out  in  WORD_W  from mem data_out.
- busy  out  1  = |gnt.

Behaviour:
Reset (nrst low, asynchronous):
- gnt=0, rvalid=0, rdata=0, rr pointer=0, hold count=0, state IDLE.
- mem_wr_en is forced 0 combinationally.
- Reset asserted mid-access aborts the access; a write in flight at that edge is not performed.

State IDLE:
- If any req is high, the first requester at or after the rr pointer (wrapping modulo NUM_REQ) receives gnt at the next edge; state becomes OWNED.
- No memory access is performed in IDLE: mem_wr_en=0, mem_address=0, mem_data_in=0.

State OWNED (owner o):
- If req[o] is high: mem_address=addr_in[o], mem_data_in=wdata_in[o], mem_wr_en=wr_en_in[o], and ack[o]=1 in the same cycle.
  - Write: committed at that edge (two bytes: address and address+1).
  - Read: mem_data_out captured into rdata at that edge; rvalid[o]=1 for exactly the next cycle.
- Release after the access when lock[o]=0, or when the hold count reaches MAX_HOLD-1.
  - On release the rr pointer becomes (o+1) mod NUM_REQ.
  - Re-arbitration happens at the same edge among other pending req (no bubble); the releasing requester is lowest priority.
  - If no other req is pending, return to IDLE.
- Otherwise the grant is kept and the hold count increments.
- If req[o] is low while granted: no access, ack=0; gnt is dropped at the next edge, the pointer advances past o, and the block re-arbitrates.

General rules:
- Hold count resets to 0 on every new grant.
- ack is never high for a non-owner. At most one ack is high per cycle.
- Worst-case wait for a requester with lock never asserted by others: NUM_REQ-1 single-access grants plus its own grant cycle.
- Address arithmetic: passed through unmodified; mem handles address+1.

Optional Feature:
MEM_ALIGN_CHECK_EN
- Defined: an owner access with addr[0]=1 or addr=2^ADDR_W-1 is rejected.
  - mem_wr_en=0, ack[o]=1, rvalid not asserted.
  - Extra output port err (1 bit, registered) pulses high for the cycle after the rejected access, and a sticky err_cnt (8 bit, saturating) increments.
- Undefined: addresses are passed through unchecked; err and err_cnt ports do not exist.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, OWNED};
  - the memory region base constants (FLAGS 0x000, KNOWN_SINKS 0x008, WORST_HOPS 0x028, NEIGHBOR_ID 0x048, CLUSTER_ID 0x0C8, BATTERY 0x148, QVALUE 0x1C8, SINK_IDS 0x248, HCM 0x648, BETTER_NBR 0x668, KNOWN_SINK_CNT 0x688, NEIGHBOR_CNT 0x68A, BETTER_NBR_CNT 0x68C, SINK_ID_CNT 0x68E);
  - the function that computes the next rr index.
- One sub-module, rr_pick: combinational round-robin priority selector (req vector plus pointer in, one-hot out plus found flag).

Test Plan:
1. Reset then req=4'b0001, wr_en_in[0]=1, addr 0x008, wdata 0x0002 → gnt[0]=1 next cycle, ack[0] that cycle, mem bytes 0x008/0x009 = 0x00/0x02; block returns to IDLE.
2. All four requesters read with no lock, addr 0x688 → grants in order 0,1,2,3. Each rvalid is one cycle after its ack. Each rdata=0x0005 with the knownSinkCount preload.
3. Requester 1 with lock=1 continuous, MAX_HOLD=16, requester 2 also pending → exactly 16 acks to requester 1, then gnt moves to 2 with no idle cycle.
4. Requester 3 drops req while granted → no ack and mem_wr_en=0 in that cycle; gnt[3] falls next edge; pending requester 0 is granted.
5. nrst pulsed low during a burst write → gnt, rvalid and mem_wr_en go 0 immediately. After release, the pointer is 0 and requester 0 wins against requester 2.
6. With MEM_ALIGN_CHECK_EN, write to 0x7FF → no memory change, ack pulses, err=1 next cycle, err_cnt=1.
